// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master arbiter:
// FSM encoding, port counts, default 3-slave address map and the
// slave-window decode helper.
package apb_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int NUM_SLV = 3;

    // Default map, in 64KB units of ADDR[31:16]
    localparam logic [15:0] DEF_START0 = 16'h0000;
    localparam logic [15:0] DEF_SIZE0  = 16'h0010;
    localparam logic [15:0] DEF_START1 = 16'h1000;
    localparam logic [15:0] DEF_SIZE1  = 16'h0010;
    localparam logic [15:0] DEF_START2 = 16'h2000;
    localparam logic [15:0] DEF_SIZE2  = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // start <= a < start+size, evaluated in 17 bits so the end of a window
    // touching 16'hFFFF does not wrap to a small value.
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] start,
                                      input logic [15:0] size);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, start};
        hi = lo + {1'b0, size};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from the current
// pointer, pointer moves to the requester that was not granted whenever
// a grant is taken.
module apb_rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               gnt_idx
);

    logic ptr;

    // ptr==0: requester 0 first; ptr==1: requester 1 first
    always_comb begin
        gnt_idx = ptr ? req[1] : ~req[0];
    end

    // advance pointer past the requester just served
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            ptr <= 1'b0;
        else if (take)
            ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two REQ/ACK requesters.
// Round-robin grant, 3-slave address decode, SETUP/ACCESS sequencing with
// PREADY wait states, RDATA/ERR returned with a one-cycle ACK.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after P_TIMEOUT
// not-ready cycles with ERR=1.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int          P_DWIDTH      = 32,
    parameter logic [15:0] P_ADDR_START0 = DEF_START0,
    parameter logic [15:0] P_ADDR_SIZE0  = DEF_SIZE0,
    parameter logic [15:0] P_ADDR_START1 = DEF_START1,
    parameter logic [15:0] P_ADDR_SIZE1  = DEF_SIZE1,
    parameter logic [15:0] P_ADDR_START2 = DEF_START2,
    parameter logic [15:0] P_ADDR_SIZE2  = DEF_SIZE2,
    parameter int          P_TIMEOUT     = 255
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [NUM_REQ-1:0]  REQ,
    input  logic [31:0]         ADDR0,
    input  logic [31:0]         ADDR1,
    input  logic [NUM_REQ-1:0]  WRITE,
    input  logic [P_DWIDTH-1:0] WDATA0,
    input  logic [P_DWIDTH-1:0] WDATA1,
    output logic [NUM_REQ-1:0]  ACK,
    output logic [P_DWIDTH-1:0] RDATA,
    output logic                ERR,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic [31:0]         PADDR,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [P_DWIDTH-1:0] PWDATA,
    input  logic [P_DWIDTH-1:0] PRDATA0,
    input  logic [P_DWIDTH-1:0] PRDATA1,
    input  logic [P_DWIDTH-1:0] PRDATA2,
    input  logic [NUM_SLV-1:0]  PREADY,
    input  logic [NUM_SLV-1:0]  PSLVERR
);

    state_t              state;
    logic                owner;     // requester that owns the transfer
    logic [1:0]          slv;       // slave index of the transfer
    logic                take;
    logic                gnt_idx;
    logic [31:0]         sel_addr;
    logic                sel_wr;
    logic [P_DWIDTH-1:0] sel_wdata;
    logic [NUM_SLV-1:0]  hit;
    logic [NUM_SLV-1:0]  hit_1h;
    logic [1:0]          hit_idx;
    logic [P_DWIDTH-1:0] prd;

`ifdef APB_TIMEOUT_EN
    localparam int TW = (P_TIMEOUT > 255) ? $clog2(P_TIMEOUT + 1) : 8;
    logic [TW-1:0] to_cnt;
`endif

    assign take = (state == ST_IDLE) && (|REQ);

    apb_rr_arbiter2 u_arb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     (REQ),
        .take    (take),
        .gnt_idx (gnt_idx)
    );

    // operands of the requester being granted, and their slave decode
    always_comb begin
        sel_addr  = gnt_idx ? ADDR1  : ADDR0;
        sel_wdata = gnt_idx ? WDATA1 : WDATA0;
        sel_wr    = WRITE[gnt_idx];
        hit[0]    = in_range(sel_addr[31:16], P_ADDR_START0, P_ADDR_SIZE0);
        hit[1]    = in_range(sel_addr[31:16], P_ADDR_START1, P_ADDR_SIZE1);
        hit[2]    = in_range(sel_addr[31:16], P_ADDR_START2, P_ADDR_SIZE2);
        hit_1h    = '0;
        hit_idx   = 2'd0;
        if (hit[0]) begin
            hit_1h = 3'b001; hit_idx = 2'd0;
        end else if (hit[1]) begin
            hit_1h = 3'b010; hit_idx = 2'd1;
        end else if (hit[2]) begin
            hit_1h = 3'b100; hit_idx = 2'd2;
        end
    end

    // read-data return mux from the active slave
    always_comb begin
        case (slv)
            2'd0:    prd = PRDATA0;
            2'd1:    prd = PRDATA1;
            default: prd = PRDATA2;
        endcase
    end

    // APB sequencing FSM; every output is a register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            slv     <= 2'd0;
            PSEL    <= '0;
            PADDR   <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            ACK     <= '0;
            RDATA   <= '0;
            ERR     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner <= gnt_idx;
                        if (|hit) begin
                            slv    <= hit_idx;
                            PSEL   <= hit_1h;
                            PADDR  <= sel_addr;
                            PWRITE <= sel_wr;
                            PWDATA <= sel_wdata;
                            state  <= ST_SETUP;
                        end else begin
                            // decode miss: answer directly, APB untouched
                            ERR   <= 1'b1;
                            RDATA <= '0;
                            ACK   <= gnt_idx ? 2'b10 : 2'b01;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY[slv]) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        RDATA   <= PWRITE ? '0 : prd;
                        ERR     <= PSLVERR[slv];
                        ACK     <= owner ? 2'b10 : 2'b01;
                        state   <= ST_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    // the P_TIMEOUT-th not-ready ACCESS cycle aborts
                    else if (to_cnt == TW'(P_TIMEOUT - 1)) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        RDATA   <= '0;
                        ERR     <= 1'b1;
                        ACK     <= owner ? 2'b10 : 2'b01;
                        state   <= ST_RESP;
                    end else begin
                        to_cnt  <= to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    // ST_RESP: ACK/RDATA/ERR live for exactly this cycle
                    ACK   <= '0;
                    ERR   <= 1'b0;
                    RDATA <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small 3-slave APB model
// (16-word memory per slave, programmable wait states and PSLVERR).
// Define APB_TIMEOUT_EN to also exercise the ACCESS timeout (P_TIMEOUT=4).
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  REQ;
    logic [31:0] ADDR0, ADDR1;
    logic [1:0]  WRITE;
    logic [31:0] WDATA0, WDATA1;
    logic [1:0]  ACK;
    logic [31:0] RDATA;
    logic        ERR;
    logic [2:0]  PSEL;
    logic [31:0] PADDR;
    logic        PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2;
    logic [2:0]  PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.P_TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .REQ(REQ),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WRITE(WRITE),
        .WDATA0(WDATA0), .WDATA1(WDATA1), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA0(PRDATA0), .PRDATA1(PRDATA1),
        .PRDATA2(PRDATA2), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // slave model
    logic [31:0] mem [3][16];
    int          nwait [3];
    int          wcnt;
    logic [2:0]  slverr;

    always_comb begin
        for (int i = 0; i < 3; i++)
            PREADY[i] = PSEL[i] && PENABLE && (wcnt >= nwait[i]);
    end
    assign PSLVERR = slverr;
    assign PRDATA0 = mem[0][PADDR[5:2]];
    assign PRDATA1 = mem[1][PADDR[5:2]];
    assign PRDATA2 = mem[2][PADDR[5:2]];

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= 0;
            for (int s = 0; s < 3; s++)
                for (int w = 0; w < 16; w++)
                    mem[s][w] <= '0;
        end else begin
            if (PENABLE && !(|(PREADY & PSEL))) wcnt <= wcnt + 1;
            else                                wcnt <= 0;
            for (int s = 0; s < 3; s++)
                if (PREADY[s] && PWRITE) mem[s][PADDR[5:2]] <= PWDATA;
        end
    end

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // results of the last xfer
    int          lat, en_cnt;
    logic [1:0]  ack_v;
    logic [31:0] rd_v;
    logic        err_v, unstable;
    logic [2:0]  psel_or;

    // one transfer from requester r; lat = cycles from REQ sampled to end of ACK
    task automatic xfer(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] pa, pw;
        logic        done;
        pa = '0; pw = '0; done = 1'b0;
        psel_or = '0; en_cnt = 0; unstable = 1'b0; ack_v = '0; rd_v = '0; err_v = 1'b0; lat = 0;
        if (r == 0) begin ADDR0 = a; WDATA0 = d; end
        else        begin ADDR1 = a; WDATA1 = d; end
        WRITE[r] = wr;
        REQ[r]   = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge PCLK); @(negedge PCLK);
            psel_or |= PSEL;
            if (PENABLE) begin
                en_cnt++;
                if (PADDR !== pa || PWDATA !== pw) unstable = 1'b1;
            end else begin
                pa = PADDR; pw = PWDATA;
            end
            if (ACK != 2'b00) begin
                ack_v = ACK; rd_v = RDATA; err_v = ERR; lat = i + 2;
                done = 1'b1; REQ[r] = 1'b0;
            end
        end
        chk("ack_seen", done, 1);
        @(posedge PCLK); @(negedge PCLK);
        chk("ack_pulse", ACK, 0);
    endtask

    logic [1:0] aseq [4];
    logic [2:0] pseq [4];
    int         na, np;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        PRESETn = 1'b0; REQ = '0; ADDR0 = '0; ADDR1 = '0; WRITE = '0;
        WDATA0 = '0; WDATA1 = '0; slverr = '0;
        for (int i = 0; i < 3; i++) nwait[i] = 0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_ctl",   {PSEL, PENABLE, PWRITE, ACK, ERR}, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_wdata", PWDATA, 0);
        chk("rst_rdata", RDATA, 0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // zero-wait write then read back on slave 0
        xfer(0, 1'b1, 32'h0000_0004, 32'h1234_5678);
        chk("wr0_lat", lat, 4);
        chk("wr0_ack", ack_v, 2'b01);
        chk("wr0_err", err_v, 0);
        chk("wr0_psel", psel_or, 3'b001);
        chk("wr0_en", en_cnt, 1);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);
        chk("rd0_data", rd_v, 32'h1234_5678);
        chk("rd0_lat", lat, 4);

        // window edges of slave 0
        xfer(1, 1'b1, 32'h000F_FFFC, 32'hCAFE_0001);
        chk("edge_hit_psel", psel_or, 3'b001);
        chk("edge_hit_ack", ack_v, 2'b10);
        xfer(0, 1'b0, 32'h0010_0000, 32'h0);
        chk("edge_miss_psel", psel_or, 3'b000);
        chk("edge_miss_err", err_v, 1);
        chk("edge_miss_lat", lat, 2);

        // unmapped address
        xfer(1, 1'b0, 32'h3000_0000, 32'h0);
        chk("miss_psel", psel_or, 3'b000);
        chk("miss_lat", lat, 2);
        chk("miss_err", err_v, 1);
        chk("miss_rdata", rd_v, 0);
        chk("miss_ack", ack_v, 2'b10);

        // both requesters, pointer fresh from reset
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        ADDR0 = 32'h1000_0000; ADDR1 = 32'h2000_0000; WRITE = 2'b00; REQ = 2'b11;
        na = 0; np = 0;
        for (int i = 0; i < 40 && na < 4; i++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (PENABLE && np < 4) begin pseq[np] = PSEL; np++; end
            if (ACK != 2'b00) begin aseq[na] = ACK; na++; end
        end
        REQ = 2'b00;
        @(posedge PCLK); @(negedge PCLK);
        chk("rr_count", na, 4);
        chk("rr_ack0", aseq[0], 2'b01);
        chk("rr_ack1", aseq[1], 2'b10);
        chk("rr_ack2", aseq[2], 2'b01);
        chk("rr_ack3", aseq[3], 2'b10);
        chk("rr_psel0", pseq[0], 3'b010);
        chk("rr_psel1", pseq[1], 3'b100);
        chk("rr_psel2", pseq[2], 3'b010);

        // three wait states on slave 1
        nwait[1] = 3;
        xfer(1, 1'b1, 32'h1000_0008, 32'hA5A5_A5A5);
        chk("wait_lat", lat, 7);
        chk("wait_en", en_cnt, 4);
        chk("wait_stable", unstable, 0);
        chk("wait_psel", psel_or, 3'b010);
        xfer(0, 1'b0, 32'h1000_0008, 32'h0);
        chk("wait_rd", rd_v, 32'hA5A5_A5A5);
        chk("wait_rd_lat", lat, 7);
        nwait[1] = 0;

        // slave error on slave 2, then error of a non-selected slave
        slverr = 3'b100;
        xfer(1, 1'b0, 32'h2000_0010, 32'h0);
        chk("slverr_err", err_v, 1);
        chk("slverr_psel", psel_or, 3'b100);
        slverr = 3'b001;
        xfer(1, 1'b0, 32'h2000_0010, 32'h0);
        chk("slverr_other", err_v, 0);
        slverr = 3'b000;

        // reset during ACCESS
        nwait[1] = 10;
        ADDR0 = 32'h1000_0000; WRITE[0] = 1'b0; REQ = 2'b01;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("mid_access", {PSEL, PENABLE}, {3'b010, 1'b1});
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_ctl", {PSEL, PENABLE, ACK, ERR}, 0);
        chk("mid_rst_paddr", PADDR, 0);
        REQ = 2'b00;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("mid_rst_noack", ACK, 0);
        PRESETn = 1'b1;
        nwait[1] = 0;
        @(negedge PCLK);

`ifdef APB_TIMEOUT_EN
        // stuck slave 0 aborts after 4 ACCESS cycles
        xfer(0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
        nwait[0] = 1000;
        xfer(0, 1'b0, 32'h0000_0000, 32'h0);
        chk("to_en", en_cnt, 4);
        chk("to_err", err_v, 1);
        chk("to_rdata", rd_v, 0);
        chk("to_lat", lat, 7);
        chk("to_ack", ack_v, 2'b01);
        nwait[0] = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one AMBA3 APB master port between two on-chip requesters, each with a simple REQ/ACK transfer interface.
- Round-robin arbitration selects one requester at a time.
- The granted address is decoded against a 3-slave map, and the block drives the APB SETUP/ACCESS protocol, including PREADY wait states.
- Read data and PSLVERR are returned to the requester that owned the transfer.
- Sits between the CPU/DMA-side requesters and the 3-slave APB segment that bfm_apb_s3 drives in simulation.

Parameters:
- P_DWIDTH, 32, APB data width.
- P_ADDR_START0, 16'h0000, slave 0 base, compared against ADDR[31:16].
- P_ADDR_SIZE0, 16'h0010, slave 0 size in 64KB units.
- P_ADDR_START1, 16'h1000, slave 1 base.
- P_ADDR_SIZE1, 16'h0010, slave 1 size.
- P_ADDR_START2, 16'h2000, slave 2 base.
- P_ADDR_SIZE2, 16'h0010, slave 2 size.
- P_TIMEOUT, 255, ACCESS-cycle limit. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- REQ  in  2  per-requester transfer request.
- ADDR0, ADDR1  in  32 each  requester address.
- WRITE  in  2  per-requester: 1=write, 0=read.
- WDATA0, WDATA1  in  P_DWIDTH each  write data.
- ACK  out  2  one-cycle completion pulse.
- RDATA  out  P_DWIDTH  read data; valid while ACK is high.
- ERR  out  1  error flag; valid while ACK is high.
- PSEL  out  3  slave selects.
- PADDR  out  32  APB address.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  P_DWIDTH  APB write data.
- PRDATA0, PRDATA1, PRDATA2  in  P_DWIDTH each  slave read data.
- PREADY  in  3  per-slave ready.
- PSLVERR  in  3  per-slave error.

Interface decision: one clock, PCLK. Reset is PRESETn, asynchronous and active-low.

Behaviour:
- Reset (async, PRESETn=0):
  - PSEL=0, PADDR=0, PENABLE=0, PWRITE=0, PWDATA=0, ACK=0, RDATA=0, ERR=0.
  - FSM=IDLE. Round-robin pointer=0, so requester 0 has priority first.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any REQ is high, grant the highest-priority requester and latch its ADDR/WRITE/WDATA.
  - Move the pointer to the other requester.
  - Decode: slave i hits when START_i <= ADDR[31:16] < START_i+SIZE_i. Use 17-bit compare so START+SIZE cannot wrap. On overlap, the lowest index wins.
  - On a hit: go to SETUP with PSEL[i]=1, PENABLE=0, PADDR/PWRITE/PWDATA loaded.
  - On a miss (decode error): go directly to RESP with ERR=1, RDATA=0. No PSEL is asserted.
- SETUP: exactly one cycle. Then go to ACCESS with PENABLE=1.
- ACCESS:
  - Hold all APB outputs stable while PREADY[i]=0.
  - When PREADY[i]=1: clear PSEL and PENABLE, capture RDATA=PRDATA_i (reads only; writes return 0), capture ERR=PSLVERR[i], go to RESP.
- RESP:
  - ACK[granted]=1 for exactly one cycle, then return to IDLE.
  - A requester keeps REQ and its operands stable until it sees ACK, and drops REQ at the edge ending RESP.
  - REQ still high in the following IDLE is treated as a new transfer.
- Latency: a zero-wait-state transfer takes 4 cycles from REQ sampled in IDLE to the end of ACK. Back-to-back transfers are not pipelined.
- Simultaneous REQ=2'b11 with pointer=0: requester 0 goes first, then requester 1. Grants alternate while both stay asserted.
- REQ changes during SETUP/ACCESS/RESP are ignored.
- Reset mid-transfer: everything clears immediately and no ACK is issued. The requester must reissue.
- PSLVERR is sampled only on the PREADY cycle.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - An 8+-bit counter clears on SETUP and increments each ACCESS cycle with PREADY[i]=0.
  - When the counter reaches P_TIMEOUT: drop PSEL/PENABLE, go to RESP with ERR=1, RDATA=0.
- When undefined: ACCESS waits indefinitely. No counter logic is generated.

Decomposition:
- Shared package apb_arb_pkg holds:
  - FSM state encodings (2-bit).
  - Slave count 3 and requester count 2.
  - Default address-map constants.
- One sub-module, apb_rr_arbiter2: 2-way round-robin grant with pointer update, combinational grant plus registered pointer.
- Decode and FSM stay in the top level.

Test Plan:
- Req0 write 0x12345678 to 0x0000_0004, zero wait: PSEL=3'b001 in SETUP then ACCESS; ACK[0] 4 cycles after request; ERR=0. Read back returns RDATA=0x12345678.
- REQ=2'b11 after reset, targets 0x1000_0000 and 0x2000_0000: req0 completes first with PSEL=3'b010, then req1 with PSEL=3'b100. Repeat with both held: grants alternate.
- Slave 1 holds PREADY low 3 cycles: PENABLE high for 4 ACCESS cycles with PADDR/PWDATA stable; ACK 7 cycles after request.
- Access to 0x3000_0000: no PSEL asserted; ACK after 2 cycles with ERR=1, RDATA=0.
- PSLVERR[2]=1 with PREADY on slave 2 read: ERR=1 alongside ACK. Also: PRESETn low during ACCESS clears all outputs within the reset cycle, with no ACK.
- APB_TIMEOUT_EN, P_TIMEOUT=4, PREADY stuck low: PSEL drops after 4 ACCESS cycles; ACK with ERR=1, RDATA=0.
